// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder
// Responder side of the CPU instruction-fetch interface. The CPU presents
// byte addresses; this block looks the word up in a small program store,
// carries the result through a fixed-latency delay line into a response
// FIFO, and hands responses back strictly in acceptance order.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   req_valid/ready   fetch handshake, req_addr is the byte address
//   resp_valid/ready  response handshake, resp_data/resp_err show FIFO head
//   load_en/addr/data program store write port (usable during reset)
//   outstanding       in-flight plus queued responses
module instr_fetch_responder #(
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           resp_err,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH)-1:0]       load_addr,
  input  logic [DATA_WIDTH-1:0]          load_data,
  output logic [$clog2(QUEUE_DEPTH):0]   outstanding
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int OW = $clog2(QUEUE_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] store_r [DEPTH];

  logic [LATENCY-1:0]    dl_valid_r;
  logic [LATENCY-1:0]    dl_err_r;
  logic [DATA_WIDTH-1:0] dl_data_r [LATENCY];

  logic [DATA_WIDTH-1:0] q_data_r [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_err_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [OW-1:0]         q_count_r;
  logic [OW-1:0]         outstanding_r;

  logic                  accept_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  fetch_err_s;
  logic [IW-1:0]         fetch_idx_s;
  logic [DATA_WIDTH-1:0] fetch_data_s;

  // Circular pointer advance; explicit wrap keeps non-power-of-two depths legal.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QUEUE_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Ready is gated by rst_n so it can never be seen high while in reset.
  assign req_ready   = rst_n && (outstanding_r < OW'(QUEUE_DEPTH));
  assign accept_s    = req_valid && req_ready;
  assign resp_valid  = (q_count_r != '0);
  assign pop_s       = resp_valid && resp_ready;
  assign push_s      = dl_valid_r[LATENCY-1];
  assign resp_data   = q_data_r[rd_ptr_r];
  assign resp_err    = q_err_r[rd_ptr_r];
  assign outstanding = outstanding_r;
  assign fetch_idx_s = req_addr[IW+1:2];

  // Decode the fetch: any nonzero upper index bit means index >= DEPTH (no aliasing).
  always_comb begin
    fetch_err_s  = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_WIDTH-1:IW+2] != '0);
    fetch_data_s = '0;
    if (fetch_err_s) begin
      fetch_data_s = '0;
    end else begin
      fetch_data_s = store_r[fetch_idx_s];
    end
  end

  // Program store write; a same-edge fetch sees the old word because the read above
  // is captured by the same edge that performs this write.
  always_ff @(posedge clk) begin
    if (load_en) begin
      store_r[load_addr] <= load_data;
    end
  end

  // Fixed-latency delay line carrying {data, err} from accept to the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_valid_r <= '0;
      dl_err_r   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_data_r[i] <= '0;
      end
    end else begin
      dl_valid_r[0] <= accept_s;
      dl_err_r[0]   <= fetch_err_s;
      dl_data_r[0]  <= fetch_data_s;
      for (int i = 1; i < LATENCY; i++) begin
        dl_valid_r[i] <= dl_valid_r[i-1];
        dl_err_r[i]   <= dl_err_r[i-1];
        dl_data_r[i]  <= dl_data_r[i-1];
      end
    end
  end

  // Response FIFO; storage is cleared on reset so resp_data reads 0 afterwards.
  // Overflow is impossible because outstanding caps entries at QUEUE_DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      q_count_r <= '0;
      q_err_r   <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        q_data_r[wr_ptr_r] <= dl_data_r[LATENCY-1];
        q_err_r[wr_ptr_r]  <= dl_err_r[LATENCY-1];
        wr_ptr_r           <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   q_count_r <= q_count_r + OW'(1);
        2'b01:   q_count_r <= q_count_r - OW'(1);
        default: q_count_r <= q_count_r;
      endcase
    end
  end

  // Outstanding count: +1 on accept, -1 on pop, unchanged when both happen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_r <= '0;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   outstanding_r <= outstanding_r + OW'(1);
        2'b01:   outstanding_r <= outstanding_r - OW'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Responder end of the CPU instruction-address interface: the CPU issues 48-bit fetch addresses and this block returns the 32-bit instruction words.
- Holds a word-addressed program store, written through a load port by the bench or boot logic.
- Serves reads with a fixed pipeline latency, buffers responses under backpressure, and flags misaligned or out-of-range fetches.

Parameters:
- ADDR_WIDTH, 48, fetch address width.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 64, program store depth in words; must be a power of two.
- LATENCY, 2, cycles from request acceptance to the response entering the output queue; minimum 1.
- QUEUE_DEPTH, 4, maximum number of outstanding responses (in flight plus queued).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  CPU presents a fetch address.
- req_ready  out  1  block can accept a fetch.
- req_addr  in  ADDR_WIDTH  byte address of the fetch.
- resp_valid  out  1  response word available.
- resp_ready  in  1  CPU consumes the response.
- resp_data  out  DATA_WIDTH  instruction word; 0 on error.
- resp_err  out  1  fetch was misaligned or out of range.
- load_en  in  1  write one word to the program store.
- load_addr  in  log2(DEPTH)  word index to write.
- load_data  in  DATA_WIDTH  word to write.
- outstanding  out  log2(QUEUE_DEPTH)+1  current count of in-flight plus queued responses.

Behaviour:
- Reset (rst_n low at a rising edge):
  - Outputs: req_ready=0 during reset, then 1 the first cycle after; resp_valid=0; resp_data=0; resp_err=0; outstanding=0.
  - Internal state: delay line cleared; queue pointers zeroed.
  - Program store contents are NOT cleared.
- Accept: a request is accepted when req_valid && req_ready at a rising edge.
  - req_ready = (outstanding < QUEUE_DEPTH) combinationally; it is never 1 during reset.
- Decode at acceptance:
  - word index = req_addr[ADDR_WIDTH-1:2].
  - err = (req_addr[1:0] != 0) || (req_addr[ADDR_WIDTH-1:2] >= DEPTH).
  - If no error, data = store[index]; otherwise data = 0.
  - The store is read at the accept edge.
- Latency and queue:
  - {data, err} traverse a LATENCY-stage delay line (one valid bit per stage).
  - They are written into a QUEUE_DEPTH-entry FIFO at the edge where they exit the last stage.
  - First possible resp_valid = 1 is LATENCY cycles after the accept edge.
- Output:
  - resp_valid = FIFO not empty; resp_data and resp_err show the FIFO head.
  - Head is popped on resp_valid && resp_ready.
  - resp_data and resp_err must hold stable while resp_valid && !resp_ready.
- Ordering: responses return strictly in acceptance order.
- outstanding:
  - Increments on accept, decrements on pop.
  - Simultaneous accept and pop leaves it unchanged.
  - Never exceeds QUEUE_DEPTH; the FIFO can never overflow, so no drop path exists.
- Full: with outstanding == QUEUE_DEPTH, req_ready=0. A pop in the same cycle does not raise req_ready until the next cycle; req_ready is computed from the registered count.
- Empty: with no valid FIFO entry, resp_valid=0 and resp_ready is ignored.
- Load port:
  - load_en writes store[load_addr] at the rising edge; this is independent of the request path and allowed during reset.
  - A load and an accepted fetch to the same word in the same cycle: the fetch returns the OLD word; the new word is visible to fetches accepted from the next cycle.
- Address wrap: none. Indices at or above DEPTH are errors, not aliased.
- Reset mid-operation: all in-flight and queued responses are discarded; no resp_valid appears after reset until new requests are accepted.

Test Plan:
- Load store[0..6] = 0x00000013+i, then fetch addresses 0,4,...,24 back-to-back with resp_ready=1 -> first resp_valid 2 cycles after the first accept; data 0x13..0x19 in order; resp_err=0; one response per cycle.
- Fetch 0x2 and fetch 0x100 (index 64) -> both resp_err=1, resp_data=0; a following fetch of 0x4 returns 0x14 with resp_err=0.
- Hold resp_ready=0 and drive 6 fetches -> exactly 4 accepted, req_ready=0 with outstanding=4. Release resp_ready -> 4 responses in order, then the remaining 2 accepted.
- Same-cycle load_en (addr 3, 0xDEADBEEF) and fetch 0xC -> old value 0x16 returned. A fetch of 0xC on the next cycle returns 0xDEADBEEF.
- With 3 outstanding, assert rst_n=0 for 1 cycle -> resp_valid=0 and outstanding=0 afterwards, and no stale response. A fresh fetch of 0x0 returns 0x13.
- Accept and pop in the same cycle at outstanding=2 -> outstanding stays 2; resp_data holds stable during a 3-cycle resp_ready=0 stall.
